// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK,
        S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Which flavour of ALU decode the current state wants.
    typedef enum logic [1:0] {CLS_ADD, CLS_EXEC, CLS_BRANCH} alu_cls_t;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic       illegal;
        alu_cls_t   cls;
    } ctrl_t;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:         imm_sel = IMM_S;
            OP_BRANCH:        imm_sel = IMM_B;
            OP_JAL:           imm_sel = IMM_J;
            OP_LUI, OP_AUIPC: imm_sel = IMM_U;
            default:          imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU operation decode and branch resolution; purely combinational.
module alu_ctrl_dec import mc_ctrl_pkg::*; (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  alu_cls_t   cls,
    output logic [3:0] alucontrol,
    output logic       taken
);

    always_comb begin
        alucontrol = ALU_ADD;
        taken      = 1'b0;
        case (cls)
            CLS_EXEC: begin
                case (funct3)
                    // funct7b5 on an I-type add is immediate bits, never sub
                    3'b000: alucontrol = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: alucontrol = ALU_SLL;
                    3'b010: alucontrol = ALU_SLT;
                    3'b011: alucontrol = ALU_SLTU;
                    3'b100: alucontrol = ALU_XOR;
                    3'b101: alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: alucontrol = ALU_OR;
                    3'b111: alucontrol = ALU_AND;
                endcase
            end
            CLS_BRANCH: begin
                case (funct3)
                    3'b000: begin alucontrol = ALU_SUB;  taken =  zero; end
                    3'b001: begin alucontrol = ALU_SUB;  taken = !zero; end
                    3'b100: begin alucontrol = ALU_SLT;  taken = !zero; end
                    3'b101: begin alucontrol = ALU_SLT;  taken =  zero; end
                    3'b110: begin alucontrol = ALU_SLTU; taken = !zero; end
                    3'b111: begin alucontrol = ALU_SLTU; taken =  zero; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and enables.
module mc_control_fsm import mc_ctrl_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] ALUControl,
    output logic       Illegal
);

    state_t     state, state_n;
    ctrl_t      c, cg;
    logic [3:0] alu_code;
    logic       taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:    if (MemReady) state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_RTYPE:          state_n = S_EXECR;
                    OP_ITYPE:          state_n = S_EXECI;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR;
                    OP_LUI:            state_n = S_LUI;
                    OP_AUIPC:          state_n = S_AUIPC;
                    default:           state_n = S_TRAP;
                endcase
            end
            S_MEMADR:   state_n = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_n = S_MEMWB;
            S_MEMWRITE: if (MemReady) state_n = S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JALRLINK: state_n = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: state_n = S_ALUWB;
            S_JALR:     state_n = S_JALRLINK;
            S_TRAP:     state_n = S_TRAP;
            default:    state_n = S_FETCH;
        endcase
    end

    always_comb begin
        c     = '0;
        c.cls = CLS_ADD;
        case (state)
            S_FETCH: begin
                c.alusrca = SRCA_PC;  c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALURES;
                c.pcwrite = MemReady; c.irwrite = MemReady;
            end
            // branch target is precomputed here and parked in ALUOut
            S_DECODE:   begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_IMM; end
            S_MEMADR:   begin c.alusrca = SRCA_RD1;   c.alusrcb = SRCB_IMM; end
            S_MEMREAD:  c.adrsrc = 1'b1;
            S_MEMWB:    begin c.resultsrc = RES_DATA; c.regwrite = 1'b1; end
            S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
            S_EXECR:    begin c.alusrca = SRCA_RD1; c.alusrcb = SRCB_RD2; c.cls = CLS_EXEC; end
            S_EXECI:    begin c.alusrca = SRCA_RD1; c.alusrcb = SRCB_IMM; c.cls = CLS_EXEC; end
            S_ALUWB:    begin c.resultsrc = RES_ALUOUT; c.regwrite = 1'b1; end
            S_JAL: begin
                c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_FOUR;
                c.resultsrc = RES_ALUOUT; c.pcwrite = 1'b1;
            end
            S_JALR: begin
                c.alusrca = SRCA_RD1; c.alusrcb = SRCB_IMM;
                c.resultsrc = RES_ALURES; c.pcwrite = 1'b1;
            end
            S_JALRLINK: begin
                c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_FOUR;
                c.resultsrc = RES_ALURES; c.regwrite = 1'b1;
            end
            S_LUI:      begin c.alusrca = SRCA_ZERO;  c.alusrcb = SRCB_IMM; end
            S_AUIPC:    begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_IMM; end
            S_BRANCH: begin
                c.alusrca = SRCA_RD1; c.alusrcb = SRCB_RD2; c.resultsrc = RES_ALUOUT;
                c.cls = CLS_BRANCH; c.pcwrite = taken;
            end
            S_TRAP:     c.illegal = 1'b1;
            default: ;
        endcase
    end

    alu_ctrl_dec u_dec (
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (Zero),
        .cls        (c.cls),
        .alucontrol (alu_code),
        .taken      (taken)
    );

    // Reset gates outputs combinationally so strobes drop without waiting for a clock.
    assign cg         = reset ? '0 : c;
    assign ALUControl = reset ? ALU_ADD : alu_code;
    assign PCWrite    = cg.pcwrite;
    assign AdrSrc     = cg.adrsrc;
    assign MemWrite   = cg.memwrite;
    assign IRWrite    = cg.irwrite;
    assign ResultSrc  = cg.resultsrc;
    assign ALUSrcA    = cg.alusrca;
    assign ALUSrcB    = cg.alusrcb;
    assign RegWrite   = cg.regwrite;
    assign Illegal    = cg.illegal;
    assign ImmSrc     = imm_sel(op);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for the multicycle control FSM: reset, R/I/load/store/branch/jump
// sequencing, ALU decode corners and the illegal-opcode trap.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    int checks = 0;
    int errors = 0;

    mc_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Leaves the FSM in FETCH, one step after the rising edge.
    task automatic do_reset;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; MemReady = 1'b1; op = 7'b0100011; funct3 = 3'b010; #2;
        checks++; if ({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal} !== 6'b0) begin
            errors++; $display("FAIL rst_enables: got %b want 000000", {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal}); end
        checks++; if ({ResultSrc, ALUSrcA, ALUSrcB, ALUControl} !== 10'b0) begin
            errors++; $display("FAIL rst_selects: got %b want 0000000000", {ResultSrc, ALUSrcA, ALUSrcB, ALUControl}); end
        checks++; if (ImmSrc !== 3'b001) begin errors++; $display("FAIL sw_immsrc: got %b want 001", ImmSrc); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if ({PCWrite, IRWrite} !== 2'b11) begin errors++; $display("FAIL fetch_ready: got %b want 11", {PCWrite, IRWrite}); end
        tick; tick; MemReady = 1'b0; tick;
        checks++; if ({MemWrite, AdrSrc} !== 2'b11) begin errors++; $display("FAIL sw_memwrite: got %b want 11", {MemWrite, AdrSrc}); end
        tick;
        checks++; if ({MemWrite, AdrSrc} !== 2'b11) begin errors++; $display("FAIL sw_memwrite_held: got %b want 11", {MemWrite, AdrSrc}); end
        #2; reset = 1'b1; #1;
        checks++; if ({MemWrite, RegWrite, PCWrite} !== 3'b000) begin
            errors++; $display("FAIL rst_async_drop: got %b want 000", {MemWrite, RegWrite, PCWrite}); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if ({PCWrite, IRWrite, ALUSrcB, ResultSrc} !== 6'b00_1010) begin
            errors++; $display("FAIL rst_fetch_stall: got %b want 001010", {PCWrite, IRWrite, ALUSrcB, ResultSrc}); end
        tick;
        checks++; if ({PCWrite, IRWrite, MemWrite} !== 3'b000) begin
            errors++; $display("FAIL rst_fetch_stall2: got %b want 000", {PCWrite, IRWrite, MemWrite}); end
        MemReady = 1'b1; #1;
        checks++; if ({PCWrite, IRWrite} !== 2'b11) begin errors++; $display("FAIL rst_fetch_go: got %b want 11", {PCWrite, IRWrite}); end
        tick;
        checks++; if ({ALUSrcA, ALUSrcB} !== 4'b0101) begin errors++; $display("FAIL rst_decode: got %b want 0101", {ALUSrcA, ALUSrcB}); end
    endtask

    task automatic test_rtype_sub;
        do_reset;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; MemReady = 1'b1; tick;
        checks++; if ({ALUSrcA, ALUSrcB} !== 4'b0101) begin errors++; $display("FAIL sub_decode: got %b want 0101", {ALUSrcA, ALUSrcB}); end
        tick;
        checks++; if ({ALUControl, ALUSrcA, ALUSrcB, RegWrite} !== 9'b0001_10_00_0) begin
            errors++; $display("FAIL sub_execr: got %b want 000110000", {ALUControl, ALUSrcA, ALUSrcB, RegWrite}); end
        tick;
        checks++; if ({RegWrite, ResultSrc, ALUControl} !== 7'b1_00_0000) begin
            errors++; $display("FAIL sub_aluwb: got %b want 1000000", {RegWrite, ResultSrc, ALUControl}); end
        tick;
        checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL sub_latency: IRWrite got %b want 1", IRWrite); end
    endtask

    task automatic test_lw_stall;
        do_reset;
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; MemReady = 1'b1; tick; tick;
        checks++; if ({ALUSrcA, ALUSrcB} !== 4'b1001) begin errors++; $display("FAIL lw_memadr: got %b want 1001", {ALUSrcA, ALUSrcB}); end
        MemReady = 1'b0; tick;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({AdrSrc, RegWrite} !== 2'b10) begin errors++; $display("FAIL lw_memread_%0d: got %b want 10", i, {AdrSrc, RegWrite}); end
            tick;
        end
        MemReady = 1'b1; #1;
        checks++; if ({AdrSrc, RegWrite} !== 2'b10) begin errors++; $display("FAIL lw_memread_last: got %b want 10", {AdrSrc, RegWrite}); end
        tick;
        checks++; if ({ResultSrc, RegWrite, AdrSrc} !== 4'b01_1_0) begin
            errors++; $display("FAIL lw_memwb: got %b want 0110", {ResultSrc, RegWrite, AdrSrc}); end
        tick;
        checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL lw_latency: IRWrite got %b want 1", IRWrite); end
    endtask

    task automatic test_branch;
        logic [2:0] f3  [8] = '{3'b110, 3'b110, 3'b000, 3'b001, 3'b100, 3'b101, 3'b111, 3'b010};
        logic       zr  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] alu [8] = '{4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0101, 4'b0101, 4'b1000, 4'b0000};
        logic       pcw [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset;
        op = 7'b1100011; MemReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            funct3 = f3[i]; Zero = zr[i]; tick; tick;
            checks++; if ({ALUControl, PCWrite, ALUSrcA, ALUSrcB} !== {alu[i], pcw[i], 4'b1000}) begin
                errors++; $display("FAIL branch_%0d: got %b want %b", i, {ALUControl, PCWrite, ALUSrcA, ALUSrcB}, {alu[i], pcw[i], 4'b1000}); end
            tick;
            checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL branch_latency_%0d: IRWrite got %b want 1", i, IRWrite); end
        end
        Zero = 1'b0;
    endtask

    task automatic test_alu_decode;
        logic [6:0] ops [5] = '{7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0010011};
        logic [2:0] f3  [5] = '{3'b101, 3'b000, 3'b101, 3'b111, 3'b100};
        logic       f7  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] alu [5] = '{4'b1111, 4'b0000, 4'b0111, 4'b0010, 4'b0110};
        do_reset;
        MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op = ops[i]; funct3 = f3[i]; funct7b5 = f7[i]; tick; tick;
            checks++; if (ALUControl !== alu[i]) begin errors++; $display("FAIL alu_dec_%0d: got %b want %b", i, ALUControl, alu[i]); end
            tick;
            checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL alu_wb_%0d: RegWrite got %b want 1", i, RegWrite); end
            tick;
        end
        funct7b5 = 1'b0;
    endtask

    task automatic test_jumps;
        do_reset;
        MemReady = 1'b1; op = 7'b1101111; tick; tick;
        checks++; if ({PCWrite, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc} !== 10'b1_01_10_00_011) begin
            errors++; $display("FAIL jal: got %b want 1011000011", {PCWrite, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc}); end
        tick; tick;
        op = 7'b1100111; tick; tick;
        checks++; if ({PCWrite, ALUSrcA, ALUSrcB, ResultSrc, RegWrite} !== 8'b1_10_01_10_0) begin
            errors++; $display("FAIL jalr: got %b want 11001100", {PCWrite, ALUSrcA, ALUSrcB, ResultSrc, RegWrite}); end
        tick;
        checks++; if ({PCWrite, ALUSrcA, ALUSrcB, ResultSrc, RegWrite} !== 8'b0_01_10_10_1) begin
            errors++; $display("FAIL jalrlink: got %b want 00110101", {PCWrite, ALUSrcA, ALUSrcB, ResultSrc, RegWrite}); end
        tick;
        checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL jalr_latency: IRWrite got %b want 1", IRWrite); end
        op = 7'b0110111; tick; tick;
        checks++; if ({ALUSrcA, ALUSrcB, ImmSrc, RegWrite} !== 8'b11_01_100_0) begin
            errors++; $display("FAIL lui: got %b want 11011000", {ALUSrcA, ALUSrcB, ImmSrc, RegWrite}); end
        tick; tick;
    endtask

    task automatic test_back_to_back;
        do_reset;
        MemReady = 1'b1; op = 7'b0100011; funct3 = 3'b010; tick; tick; tick;
        checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL b2b_sw: MemWrite got %b want 1", MemWrite); end
        tick;
        checks++; if ({IRWrite, MemWrite} !== 2'b10) begin errors++; $display("FAIL b2b_sw_done: got %b want 10", {IRWrite, MemWrite}); end
        op = 7'b0010011; funct3 = 3'b000; tick; tick;
        checks++; if ({ALUSrcB, ALUControl} !== 6'b01_0000) begin errors++; $display("FAIL b2b_addi: got %b want 010000", {ALUSrcB, ALUControl}); end
        tick; tick;
        checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL b2b_latency: IRWrite got %b want 1", IRWrite); end
    endtask

    task automatic test_trap;
        do_reset;
        MemReady = 1'b1; op = 7'b1111111; tick;
        checks++; if ({ALUSrcA, Illegal} !== 3'b010) begin errors++; $display("FAIL trap_decode: got %b want 010", {ALUSrcA, Illegal}); end
        for (int i = 0; i < 12; i++) begin
            tick; MemReady = ~MemReady;
            checks++; if ({Illegal, PCWrite, IRWrite, MemWrite, RegWrite} !== 5'b10000) begin
                errors++; $display("FAIL trap_hold_%0d: got %b want 10000", i, {Illegal, PCWrite, IRWrite, MemWrite, RegWrite}); end
        end
        @(negedge clk); reset = 1'b1; #1;
        checks++; if (Illegal !== 1'b0) begin errors++; $display("FAIL trap_reset: Illegal got %b want 0", Illegal); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset;
        test_rtype_sub;
        test_lw_stall;
        test_branch;
        test_alu_decode;
        test_jumps;
        test_back_to_back;
        test_trap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
